// File: rtl/tmr_pkg.sv
// Shared types and constants for the TMR supervisory controller.
// The bundle is {pc, alu, rd2, mem_write} for one core.
package tmr_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      RESYNC = 2'd1,
      HALT   = 2'd2
   } tmr_state_e;

   localparam int         DATA_W_DEF  = 32;
   localparam int         BUNDLE_W    = 3 * DATA_W_DEF + 1;
   localparam logic [1:0] INJECT_NONE = 2'd3;

   function automatic int bundle_width(input int data_w);
      return 3 * data_w + 1;
   endfunction

endpackage

// File: rtl/tmr_majority_voter.sv
// Bitwise 2-of-3 majority voter with per-input disagreement flags.
// Also reports loss of majority when all three inputs differ pairwise.
module tmr_majority_voter #(
   parameter int W = 97
) (
   input  logic [W-1:0] in0,
   input  logic [W-1:0] in1,
   input  logic [W-1:0] in2,
   output logic [W-1:0] voted,
   output logic [2:0]   disagree,
   output logic         no_majority
);

   assign voted = (in0 & in1) | (in0 & in2) | (in1 & in2);

   assign disagree[0] = (in0 != voted);
   assign disagree[1] = (in1 != voted);
   assign disagree[2] = (in2 != voted);

   assign no_majority = (in0 != in1) && (in0 != in2) && (in1 != in2);

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// TMR supervisor: votes the three cores, resynchronises a persistently faulty
// core, halts on loss of majority and schedules error-injection pulses.
module tmr_recovery_ctrl
   import tmr_pkg::*;
#(
   parameter int DATA_W        = DATA_W_DEF,
   parameter int ERR_THRESH    = 3,
   parameter int RESYNC_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_in,
   input  logic [DATA_W-1:0] pc0,
   input  logic [DATA_W-1:0] pc1,
   input  logic [DATA_W-1:0] pc2,
   input  logic [DATA_W-1:0] alu0,
   input  logic [DATA_W-1:0] alu1,
   input  logic [DATA_W-1:0] alu2,
   input  logic [DATA_W-1:0] rd2_0,
   input  logic [DATA_W-1:0] rd2_1,
   input  logic [DATA_W-1:0] rd2_2,
   input  logic [2:0]        mw_in,
   input  logic              inject_req,
   input  logic [1:0]        inject_sel,
   output logic [DATA_W-1:0] voted_pc,
   output logic [DATA_W-1:0] voted_alu,
   output logic [DATA_W-1:0] voted_rd2,
   output logic              voted_mw,
   output logic [2:0]        core_rst,
   output logic [2:0]        inject_error,
   output logic [1:0]        fault_core,
   output logic              recovering,
   output logic              fatal,
   output logic [15:0]       mismatch_cnt,
   output logic [7:0]        recovery_cnt
);

   localparam int BW = bundle_width(DATA_W);
   localparam int CW = $clog2(ERR_THRESH + 1);
   localparam int RW = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ERR_THRESH - 1);
   localparam logic [RW-1:0] RS_LOAD  = RW'(RESYNC_CYCLES - 1);

   logic [BW-1:0] bundle0_s, bundle1_s, bundle2_s, voted_s;
   logic [2:0]    disagree_s, hit_s, core_rst_s;
   logic          no_majority_s, enter_resync_s, exit_resync_s;
   logic          recovering_s, fatal_s;
   logic [1:0]    fault_sel_s;
   tmr_state_e    state_r, next_s;
   logic [CW-1:0] err_cnt_r [3];
   logic [RW-1:0] rs_cnt_r;
   logic [15:0]   mis_cnt_r;
   logic [7:0]    rec_cnt_r;
   logic [1:0]    fault_r;
   logic [2:0]    inject_r;

   assign bundle0_s = {pc0, alu0, rd2_0, mw_in[0]};
   assign bundle1_s = {pc1, alu1, rd2_1, mw_in[1]};
   assign bundle2_s = {pc2, alu2, rd2_2, mw_in[2]};

   tmr_majority_voter #(.W(BW)) u_voter (
      .in0         (bundle0_s),
      .in1         (bundle1_s),
      .in2         (bundle2_s),
      .voted       (voted_s),
      .disagree    (disagree_s),
      .no_majority (no_majority_s)
   );

   assign voted_pc  = voted_s[3*DATA_W:2*DATA_W+1];
   assign voted_alu = voted_s[2*DATA_W:DATA_W+1];
   assign voted_rd2 = voted_s[DATA_W:1];
   assign voted_mw  = voted_s[0] & (state_r == RUN);

   // Threshold detection and lowest-index faulty core selection
   always_comb begin
      hit_s = 3'b000;
      for (int k = 0; k < 3; k++) begin
         hit_s[k] = disagree_s[k] && (err_cnt_r[k] == CNT_LAST);
      end
      if (hit_s[0]) begin
         fault_sel_s = 2'd0;
      end else if (hit_s[1]) begin
         fault_sel_s = 2'd1;
      end else if (hit_s[2]) begin
         fault_sel_s = 2'd2;
      end else begin
         fault_sel_s = 2'd0;
      end
   end

   // FSM next-state and state-decoded outputs
   always_comb begin
      next_s         = state_r;
      enter_resync_s = 1'b0;
      exit_resync_s  = 1'b0;
      core_rst_s     = 3'b000;
      recovering_s   = 1'b0;
      fatal_s        = 1'b0;
      case (state_r)
         RUN: begin
            if (no_majority_s) begin
               next_s = HALT;
            end else if (|hit_s) begin
               next_s         = RESYNC;
               enter_resync_s = 1'b1;
            end else begin
               next_s = RUN;
            end
         end
         RESYNC: begin
            core_rst_s   = 3'b111;
            recovering_s = 1'b1;
            if (rs_cnt_r == {RW{1'b0}}) begin
               next_s        = RUN;
               exit_resync_s = 1'b1;
            end else begin
               next_s = RESYNC;
            end
         end
         HALT: begin
            core_rst_s = 3'b111;
            fatal_s    = 1'b1;
            next_s     = HALT;
         end
         default: begin
            next_s = RUN;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_r <= RUN;
      end else begin
         state_r <= next_s;
      end
   end

   // Per-core consecutive-disagreement counters
   always_ff @(posedge clk) begin
      if (rst_in || exit_resync_s) begin
         for (int k = 0; k < 3; k++) err_cnt_r[k] <= {CW{1'b0}};
      end else if (state_r == RUN) begin
         for (int k = 0; k < 3; k++) begin
            if (disagree_s[k]) begin
               err_cnt_r[k] <= err_cnt_r[k] + CW'(1);
            end else begin
               err_cnt_r[k] <= {CW{1'b0}};
            end
         end
      end
   end

   // Resync hold timer, loaded on entry and counted down to zero
   always_ff @(posedge clk) begin
      if (rst_in) begin
         rs_cnt_r <= {RW{1'b0}};
      end else if (enter_resync_s) begin
         rs_cnt_r <= RS_LOAD;
      end else if ((state_r == RESYNC) && (rs_cnt_r != {RW{1'b0}})) begin
         rs_cnt_r <= rs_cnt_r - RW'(1);
      end
   end

   // Saturating statistics and faulty-core latch
   always_ff @(posedge clk) begin
      if (rst_in) begin
         mis_cnt_r <= 16'd0;
         rec_cnt_r <= 8'd0;
         fault_r   <= 2'd0;
      end else begin
         if ((state_r == RUN) && (|disagree_s) && (mis_cnt_r != 16'hFFFF)) begin
            mis_cnt_r <= mis_cnt_r + 16'd1;
         end
         if (enter_resync_s) begin
            fault_r <= fault_sel_s;
            if (rec_cnt_r != 8'hFF) begin
               rec_cnt_r <= rec_cnt_r + 8'd1;
            end
         end
      end
   end

   // One-cycle injection pulse, accepted only while running
   always_ff @(posedge clk) begin
      if (rst_in) begin
         inject_r <= 3'b000;
      end else if ((state_r == RUN) && inject_req && (inject_sel != INJECT_NONE)) begin
         inject_r <= 3'b001 << inject_sel;
      end else begin
         inject_r <= 3'b000;
      end
   end

   assign core_rst     = core_rst_s;
   assign recovering   = recovering_s;
   assign fatal        = fatal_s;
   assign fault_core   = fault_r;
   assign mismatch_cnt = mis_cnt_r;
   assign recovery_cnt = rec_cnt_r;
   assign inject_error = inject_r;

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Scoreboard bench for tmr_recovery_ctrl: a cycle model pushes expected
// outputs each cycle, which are popped and compared against the DUT.
module tb_tmr_recovery_ctrl;

   localparam int TH = 3;
   localparam int RC = 4;

   logic        clk = 1'b0;
   logic        rst_in;
   logic [31:0] pc0, pc1, pc2, alu0, alu1, alu2, rd2_0, rd2_1, rd2_2;
   logic [2:0]  mw_in;
   logic        inject_req;
   logic [1:0]  inject_sel;
   logic [31:0] voted_pc, voted_alu, voted_rd2;
   logic        voted_mw, recovering, fatal;
   logic [2:0]  core_rst, inject_error;
   logic [1:0]  fault_core;
   logic [15:0] mismatch_cnt;
   logic [7:0]  recovery_cnt;

   tmr_recovery_ctrl #(.DATA_W(32), .ERR_THRESH(TH), .RESYNC_CYCLES(RC)) dut (
      .clk(clk), .rst_in(rst_in),
      .pc0(pc0), .pc1(pc1), .pc2(pc2),
      .alu0(alu0), .alu1(alu1), .alu2(alu2),
      .rd2_0(rd2_0), .rd2_1(rd2_1), .rd2_2(rd2_2),
      .mw_in(mw_in), .inject_req(inject_req), .inject_sel(inject_sel),
      .voted_pc(voted_pc), .voted_alu(voted_alu), .voted_rd2(voted_rd2),
      .voted_mw(voted_mw), .core_rst(core_rst), .inject_error(inject_error),
      .fault_core(fault_core), .recovering(recovering), .fatal(fatal),
      .mismatch_cnt(mismatch_cnt), .recovery_cnt(recovery_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, alu, rd2;
      logic        mw;
      logic [2:0]  rst, inj;
      logic [1:0]  fault;
      logic        rec, fat;
      logic [15:0] mis;
      logic [7:0]  rcnt;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   // model state: 0 run, 1 resync, 2 halt
   int         m_state, m_rs, m_mis, m_rec;
   int         m_cnt [3];
   logic [1:0] m_fault;
   logic [2:0] m_inj;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [96:0] maj3(input logic [96:0] a, input logic [96:0] b, input logic [96:0] c);
      logic [96:0] r;
      int s;
      for (int i = 0; i < 97; i++) begin
         s = int'(a[i]) + int'(b[i]) + int'(c[i]);
         r[i] = (s >= 2);
      end
      return r;
   endfunction

   function automatic exp_t model_expect();
      exp_t e;
      logic [96:0] v;
      v = maj3({pc0, alu0, rd2_0, mw_in[0]}, {pc1, alu1, rd2_1, mw_in[1]}, {pc2, alu2, rd2_2, mw_in[2]});
      e.pc    = v[96:65];
      e.alu   = v[64:33];
      e.rd2   = v[32:1];
      e.mw    = v[0] && (m_state == 0);
      e.rst   = (m_state != 0) ? 3'b111 : 3'b000;
      e.inj   = m_inj;
      e.fault = m_fault;
      e.rec   = (m_state == 1);
      e.fat   = (m_state == 2);
      e.mis   = 16'(m_mis);
      e.rcnt  = 8'(m_rec);
      return e;
   endfunction

   task automatic model_reset();
      m_state = 0; m_rs = 0; m_mis = 0; m_rec = 0;
      m_fault = 2'd0; m_inj = 3'b000;
      for (int k = 0; k < 3; k++) m_cnt[k] = 0;
   endtask

   task automatic model_advance();
      logic [96:0] b [3];
      logic [96:0] v;
      logic [2:0]  dis;
      int          first_hit;
      b[0] = {pc0, alu0, rd2_0, mw_in[0]};
      b[1] = {pc1, alu1, rd2_1, mw_in[1]};
      b[2] = {pc2, alu2, rd2_2, mw_in[2]};
      v = maj3(b[0], b[1], b[2]);
      for (int k = 0; k < 3; k++) dis[k] = (b[k] != v);
      if (rst_in) begin
         model_reset();
      end else if (m_state == 0) begin
         first_hit = -1;
         for (int k = 2; k >= 0; k--) if (dis[k] && m_cnt[k] == TH - 1) first_hit = k;
         if (dis != 3'b000 && m_mis < 65535) m_mis++;
         m_inj = (inject_req && inject_sel != 2'd3) ? (3'b001 << inject_sel) : 3'b000;
         for (int k = 0; k < 3; k++) m_cnt[k] = dis[k] ? m_cnt[k] + 1 : 0;
         if (b[0] != b[1] && b[0] != b[2] && b[1] != b[2]) begin
            m_state = 2;
         end else if (first_hit >= 0) begin
            m_state = 1;
            m_rs    = RC - 1;
            m_fault = 2'(first_hit);
            if (m_rec < 255) m_rec++;
         end
      end else if (m_state == 1) begin
         m_inj = 3'b000;
         if (m_rs == 0) begin
            m_state = 0;
            for (int k = 0; k < 3; k++) m_cnt[k] = 0;
         end else begin
            m_rs--;
         end
      end else begin
         m_inj = 3'b000;
      end
   endtask

   // One clock cycle: push expectation, sample away from the edge, pop and compare
   task automatic step();
      exp_t e;
      sb_q.push_back(model_expect());
      #2;
      e = sb_q.pop_front();
      check_eq("voted_pc", voted_pc, e.pc);
      check_eq("voted_alu", voted_alu, e.alu);
      check_eq("voted_rd2", voted_rd2, e.rd2);
      check_eq("voted_mw", {31'd0, voted_mw}, {31'd0, e.mw});
      check_eq("core_rst", {29'd0, core_rst}, {29'd0, e.rst});
      check_eq("inject_error", {29'd0, inject_error}, {29'd0, e.inj});
      check_eq("fault_core", {30'd0, fault_core}, {30'd0, e.fault});
      check_eq("recovering", {31'd0, recovering}, {31'd0, e.rec});
      check_eq("fatal", {31'd0, fatal}, {31'd0, e.fat});
      check_eq("mismatch_cnt", {16'd0, mismatch_cnt}, {16'd0, e.mis});
      check_eq("recovery_cnt", {24'd0, recovery_cnt}, {24'd0, e.rcnt});
      model_advance();
      @(negedge clk);
   endtask

   task automatic set_all(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d, input logic [2:0] mw);
      pc0 = p;   pc1 = p;   pc2 = p;
      alu0 = a;  alu1 = a;  alu2 = a;
      rd2_0 = d; rd2_1 = d; rd2_2 = d;
      mw_in = mw;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_in = 1'b1; inject_req = 1'b0; inject_sel = 2'd3;
      set_all(32'h100, 32'h200, 32'h300, 3'b000);
      repeat (2) @(negedge clk);
      model_reset();
      rst_in = 1'b0;

      // reset state, identical cores
      step(); step();
      check_eq("init_voted_pc", voted_pc, 32'h100);
      check_eq("init_core_rst", {29'd0, core_rst}, 32'd0);
      check_eq("init_mis", {16'd0, mismatch_cnt}, 32'd0);

      // core 2 alu wrong for two cycles only
      alu2 = 32'h999; step(); step();
      alu2 = 32'h200; step();
      check_eq("t2_mis", {16'd0, mismatch_cnt}, 32'd2);
      check_eq("t2_recovering", {31'd0, recovering}, 32'd0);
      check_eq("t2_voted_alu", voted_alu, 32'h200);

      // core 1 pc wrong for three cycles -> resync
      set_all(32'h100, 32'h200, 32'h300, 3'b111);
      pc1 = 32'h104; step(); step(); step();
      pc1 = 32'h100;
      check_eq("t3_recovering", {31'd0, recovering}, 32'd1);
      check_eq("t3_core_rst", {29'd0, core_rst}, 32'd7);
      check_eq("t3_voted_mw", {31'd0, voted_mw}, 32'd0);
      check_eq("t3_fault_core", {30'd0, fault_core}, 32'd1);
      check_eq("t3_rec_cnt", {24'd0, recovery_cnt}, 32'd1);
      check_eq("t3_mis", {16'd0, mismatch_cnt}, 32'd5);
      inject_req = 1'b1; inject_sel = 2'd0; step();
      inject_req = 1'b0;
      check_eq("t3_inj_dropped", {29'd0, inject_error}, 32'd0);
      step(); step();
      check_eq("t3_still_resync", {31'd0, recovering}, 32'd1);
      step();
      check_eq("t3_back_run", {31'd0, recovering}, 32'd0);
      check_eq("t3_run_mw", {31'd0, voted_mw}, 32'd1);

      // broken run of disagreements does not trigger
      pc1 = 32'h104; step(); step();
      pc1 = 32'h100; step();
      pc1 = 32'h104; step();
      pc1 = 32'h100; step();
      check_eq("t3b_no_resync", {31'd0, recovering}, 32'd0);
      check_eq("t3b_mis", {16'd0, mismatch_cnt}, 32'd8);

      // injection: back-to-back pulses, none for sel=3
      inject_req = 1'b1; inject_sel = 2'd2; step();
      check_eq("t4_inj_sel2", {29'd0, inject_error}, 32'h4);
      inject_sel = 2'd0; step();
      check_eq("t4_inj_sel0", {29'd0, inject_error}, 32'h1);
      inject_sel = 2'd1; step();
      check_eq("t4_inj_sel1", {29'd0, inject_error}, 32'h2);
      inject_sel = 2'd3; step();
      check_eq("t4_inj_none", {29'd0, inject_error}, 32'h0);
      inject_req = 1'b0; step();
      check_eq("t4_inj_idle", {29'd0, inject_error}, 32'h0);

      // reset during the second resync cycle
      rd2_0 = 32'h777; step(); step(); step();
      rd2_0 = 32'h300;
      check_eq("t5_fault_core", {30'd0, fault_core}, 32'd0);
      check_eq("t5_rec_cnt", {24'd0, recovery_cnt}, 32'd2);
      step();
      rst_in = 1'b1; step();
      rst_in = 1'b0;
      check_eq("t5_core_rst", {29'd0, core_rst}, 32'd0);
      check_eq("t5_recovering", {31'd0, recovering}, 32'd0);
      check_eq("t5_mis", {16'd0, mismatch_cnt}, 32'd0);
      check_eq("t5_rec_cnt0", {24'd0, recovery_cnt}, 32'd0);
      step();

      // loss of majority -> halt until reset
      pc0 = 32'h10; pc1 = 32'h20; pc2 = 32'h30; step();
      check_eq("t6_fatal", {31'd0, fatal}, 32'd1);
      check_eq("t6_core_rst", {29'd0, core_rst}, 32'd7);
      set_all(32'h100, 32'h200, 32'h300, 3'b111);
      step(); step(); step();
      check_eq("t6_stay_halt", {31'd0, fatal}, 32'd1);
      check_eq("t6_voted_mw", {31'd0, voted_mw}, 32'd0);
      rst_in = 1'b1; step();
      rst_in = 1'b0;
      check_eq("t6_after_rst", {31'd0, fatal}, 32'd0);
      check_eq("t6_after_rst_core", {29'd0, core_rst}, 32'd0);
      step();

      // random mix of faults and injections
      for (int it = 0; it < 60; it++) begin
         int r;
         r = int'($urandom_range(0, 9));
         set_all(32'h100, 32'h200, 32'h300, 3'b111);
         if (r < 3) pc1 = $urandom;
         else if (r == 3) alu0 = $urandom;
         else if (r == 4) begin pc0 = 32'h1; pc1 = 32'h2; pc2 = 32'h4; end
         else if (r == 5) mw_in = 3'b011;
         inject_req = $urandom_range(0, 1) == 1;
         inject_sel = 2'($urandom_range(0, 3));
         rst_in = (m_state == 2);
         step();
      end
      rst_in = 1'b0; inject_req = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/tmr_recovery_ctrl.md
# tmr_recovery_ctrl

Supervisory controller for the triple-modular-redundant processor. It sits between three lock-stepped core instances and the shared data memory. Each cycle it majority-votes the cores' architectural outputs and tracks per-core persistent disagreement. It sequences a timed resynchronisation reset when a core is persistently faulty, and halts on loss of majority. It also schedules single-cycle error-injection pulses into a selected core for fault campaigns.

## Interface
Parameters:
- DATA_W, 32, width of PC / ALU result / store-data fields
- ERR_THRESH, 3, consecutive disagreeing cycles before recovery (≥1)
- RESYNC_CYCLES, 4, cycles all cores are held in reset during recovery (≥1)

Ports:
- clk  in  1  system clock
- rst_in  in  1  synchronous reset, active-high
- pc0, pc1, pc2  in  DATA_W  core program counters
- alu0, alu1, alu2  in  DATA_W  core ALU results (memory address)
- rd2_0, rd2_1, rd2_2  in  DATA_W  core store data
- mw_in  in  3  core MemWrite, bit k = core k
- inject_req  in  1  request one injection pulse
- inject_sel  in  2  target core for inject_req (3 = none)
- voted_pc, voted_alu, voted_rd2  out  DATA_W  bitwise majority values
- voted_mw  out  1  majority MemWrite, gated to 0 outside RUN
- core_rst  out  3  per-core reset request (OR'd into each core's rst_in)
- inject_error  out  3  one-hot injection pulse to core Error_injection
- fault_core  out  2  index of last core that triggered recovery
- recovering  out  1  high in RESYNC
- fatal  out  1  high in HALT
- mismatch_cnt  out  16  saturating count of RUN cycles with any disagreement
- recovery_cnt  out  8  saturating count of RESYNC entries

## Operation
- Bundle k = {pc_k, alu_k, rd2_k, mw_in[k]}, 3·DATA_W+1 bits. Voted bundle = bitwise majority of the three.
- disagree[k] = (bundle k ≠ voted bundle). no_majority = all three bundles pairwise unequal.
- Each core has a consecutive-disagree counter, width ceil(log2(ERR_THRESH+1)). In RUN it increments when disagree[k] and clears when not.
- FSM states: RUN, RESYNC, HALT. Reset state is RUN.
- RUN → HALT when no_majority. This has priority over the threshold.
- RUN → RESYNC when any core has disagree[k] with counter = ERR_THRESH−1. fault_core latches the lowest such k. recovery_cnt increments, saturating at 255.
- RESYNC: core_rst = 3'b111. A down-counter loads RESYNC_CYCLES−1 on entry. Exit to RUN when it reaches 0. All disagree counters are cleared on exit.
- HALT: core_rst = 3'b111, fatal = 1. Left only via rst_in.
- mismatch_cnt increments in RUN when |disagree, saturating at 0xFFFF. It holds in other states.
- Injection is accepted only in RUN with inject_sel ≠ 3: inject_error[inject_sel] = 1 for exactly the next cycle. Requests in RESYNC/HALT or with sel=3 are dropped. Back-to-back requests yield back-to-back pulses.
- Reset values: state RUN; core_rst 0; inject_error 0; fault_core 0; recovering 0; fatal 0; all counters 0.

## Timing
- Voted data outputs are combinational from inputs, zero latency.
- voted_mw is combinational majority ANDed with registered (state==RUN). It is 0 from the first RESYNC/HALT cycle onward.
- core_rst, recovering and fatal are decoded from the state register. They take effect the cycle after the triggering condition.
- Example with ERR_THRESH=3: core 1 disagrees in cycles n, n+1, n+2. State is RESYNC from n+3 through n+3+RESYNC_CYCLES−1, and RUN again from then.
- A single agreeing cycle in between resets the count, so disagreements at n, n+1, n+3 do not trigger.
- rst_in during RESYNC or HALT returns to RUN next cycle, with all outputs at reset values.
- inject_error is registered: request in cycle n → pulse in cycle n+1.

## Structure
- Package tmr_pkg: state enum (RUN, RESYNC, HALT), DATA_W default, bundle width constant, INJECT_NONE = 2'd3.
- Sub-module tmr_majority_voter: parameterised width, three inputs. Outputs are the voted vector, disagree[2:0] and no_majority. One instance operates on the full bundle.
- The FSM, counters and injection register live in the top module.

## Test plan
- Reset, identical inputs (pc=0x100 on all cores) → voted_pc=0x100, disagree=0, core_rst=0, counts 0.
- Core 2 alu differs for 2 cycles, then agrees → no RESYNC, mismatch_cnt=2, voted_alu equals the core 0/1 value throughout.
- Core 1 pc differs for 3 consecutive cycles with mw_in=3'b111 → RESYNC from the next cycle for 4 cycles. core_rst=3'b111, voted_mw=0, fault_core=1, recovery_cnt=1, then RUN.
- pc0=0x10, pc1=0x20, pc2=0x30 → HALT next cycle, fatal=1, stays in HALT until rst_in; after rst_in, state RUN.
- inject_req with sel=2 in RUN → inject_error=3'b100 for one cycle. sel=3, or a request during RESYNC → inject_error stays 0.
- rst_in asserted in 2nd RESYNC cycle → next cycle core_rst=0, recovering=0, counters 0.
